// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, write-first bypass,
// hardwired-zero register 0 and a per-register busy scoreboard for issue/writeback hazards.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_set_reg,
  output logic              busy_A,
  output logic              busy_B,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [WIDTH-1:0] r_regs [1:DEPTH-1];
  logic [DEPTH-1:0] r_busy;

  logic [WIDTH-1:0] w_stored_a;
  logic [WIDTH-1:0] w_stored_b;
  logic             w_wb_hit_a;
  logic             w_wb_hit_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(i)) r_regs[i] <= data_writeReg;
        // A new issue to the same register outranks the retiring writeback.
        if (busy_set && busy_set_reg == ADDR_W'(i))
          r_busy[i] <= 1'b1;
        else if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_stored_a = '0;
    w_stored_b = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ctrl_readRegA == ADDR_W'(i)) w_stored_a = r_regs[i];
      if (ctrl_readRegB == ADDR_W'(i)) w_stored_b = r_regs[i];
    end
  end

  assign w_wb_hit_a = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != '0);
  assign w_wb_hit_b = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != '0);

  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    busy_A        = 1'b0;
    busy_B        = 1'b0;
    busy_vec      = '0;
    if (!reset) begin
      data_readRegA = w_wb_hit_a ? data_writeReg : w_stored_a;
      data_readRegB = w_wb_hit_b ? data_writeReg : w_stored_b;
      // A same-cycle writeback resolves the hazard, matching the data bypass.
      busy_A        = r_busy[ctrl_readRegA] && !w_wb_hit_a;
      busy_B        = r_busy[ctrl_readRegB] && !w_wb_hit_b;
      busy_vec      = {r_busy[DEPTH-1:1], 1'b0};
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard, plus a small-parameter instance.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] da;
  logic [31:0] db;
  logic        bs;
  logic [4:0]  bsr;
  logic        ba;
  logic        bb;
  logic [31:0] bvec;

  logic        p_reset;
  logic        p_we;
  logic [1:0]  p_wr;
  logic [7:0]  p_wd;
  logic [1:0]  p_ra;
  logic [1:0]  p_rb;
  logic [7:0]  p_da;
  logic [7:0]  p_db;
  logic        p_bs;
  logic [1:0]  p_bsr;
  logic        p_ba;
  logic        p_bb;
  logic [3:0]  p_bvec;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(da), .data_readRegB(db),
    .busy_set(bs), .busy_set_reg(bsr),
    .busy_A(ba), .busy_B(bb), .busy_vec(bvec)
  );

  regfile_scoreboard #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut_small (
    .clk(clk), .reset(p_reset),
    .ctrl_writeEnable(p_we), .ctrl_writeReg(p_wr), .data_writeReg(p_wd),
    .ctrl_readRegA(p_ra), .ctrl_readRegB(p_rb),
    .data_readRegA(p_da), .data_readRegB(p_db),
    .busy_set(p_bs), .busy_set_reg(p_bsr),
    .busy_A(p_ba), .busy_B(p_bb), .busy_vec(p_bvec)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        bs;
    logic [4:0]  bsr;
    logic [31:0] exp_da;
    logic [31:0] exp_db;
    logic        exp_ba;
    logic        exp_bb;
    logic [31:0] exp_vec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic [4:0] a_wr, logic [31:0] a_wd,
                              logic [4:0] a_ra, logic [4:0] a_rb, logic s, logic [4:0] a_bsr,
                              logic [31:0] e_da, logic [31:0] e_db, logic e_ba, logic e_bb,
                              logic [31:0] e_vec);
    vec_t v;
    v.rst = r; v.we = w; v.wr = a_wr; v.wd = a_wd; v.ra = a_ra; v.rb = a_rb;
    v.bs = s; v.bsr = a_bsr; v.exp_da = e_da; v.exp_db = e_db;
    v.exp_ba = e_ba; v.exp_bb = e_bb; v.exp_vec = e_vec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wr = '0; wd = '0; ra = '0; rb = '0; bs = 1'b0; bsr = '0;
    p_reset = 1'b1; p_we = 1'b0; p_wr = '0; p_wd = '0; p_ra = '0; p_rb = '0;
    p_bs = 1'b0; p_bsr = '0;

    //            rst we wr  wd            ra  rb  bs bsr  exp_da        exp_db        ba bb vec
    vecs.push_back(mk(1, 0, 0,  32'h0,        5,  31, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 3,  32'hDEADBEEF, 3,  3,  0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        3,  5,  0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 7,  32'h12345678, 7,  0,  0, 0,  32'h12345678, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        7,  0,  0, 0,  32'h12345678, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0,  32'hFFFFFFFF, 0,  7,  0, 0,  32'h0,        32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 9,  32'h1,        9,  9,  0, 0,  32'h1,        32'h1,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 9,  32'hABCD,     9,  9,  0, 0,  32'hABCD,     32'hABCD,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        9,  7,  0, 0,  32'hABCD,     32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        4,  4,  1, 4,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        4,  9,  0, 0,  32'h0,        32'hABCD,     1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 4,  32'h44,       4,  4,  0, 0,  32'h44,       32'h44,       0, 0, 32'h10));
    vecs.push_back(mk(0, 0, 0,  32'h0,        4,  4,  0, 0,  32'h44,       32'h44,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        6,  6,  1, 6,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 6,  32'h55,       6,  6,  1, 6,  32'h55,       32'h55,       0, 0, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        6,  0,  0, 0,  32'h55,       32'h0,        1, 0, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0,  6,  1, 0,  32'h0,        32'h55,       0, 1, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        32'h0,        0, 0, 32'h40));
    vecs.push_back(mk(0, 1, 8,  32'h8,        8,  6,  1, 6,  32'h8,        32'h55,       0, 1, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        8,  6,  0, 0,  32'h8,        32'h55,       0, 1, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        31, 1,  1, 31, 32'h0,        32'h0,        0, 0, 32'h40));
    vecs.push_back(mk(0, 0, 0,  32'h0,        31, 6,  0, 0,  32'h0,        32'h55,       1, 1, 32'h80000040));
    vecs.push_back(mk(1, 1, 6,  32'h77,       6,  31, 1, 10, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        6,  31, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,  32'h0,        10, 8,  0, 0,  32'h0,        32'h0,        0, 0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; we = vecs[i].we; wr = vecs[i].wr; wd = vecs[i].wd;
      ra = vecs[i].ra; rb = vecs[i].rb; bs = vecs[i].bs; bsr = vecs[i].bsr;
      #1;
      check("data_readRegA", i, 64'(da),   64'(vecs[i].exp_da));
      check("data_readRegB", i, 64'(db),   64'(vecs[i].exp_db));
      check("busy_A",        i, 64'(ba),   64'(vecs[i].exp_ba));
      check("busy_B",        i, 64'(bb),   64'(vecs[i].exp_bb));
      check("busy_vec",      i, 64'(bvec), 64'(vecs[i].exp_vec));
    end

    // Small configuration: write and issue in the same cycle, then observe both.
    @(negedge clk);
    p_reset = 1'b0; p_we = 1'b1; p_wr = 2'd3; p_wd = 8'hA5;
    p_bs = 1'b1; p_bsr = 2'd2; p_ra = 2'd3; p_rb = 2'd2;
    #1;
    check("small_bypass_A", 100, 64'(p_da),   64'hA5);
    check("small_busy_B0",  100, 64'(p_bb),   64'h0);
    check("small_vec0",     100, 64'(p_bvec), 64'h0);
    @(negedge clk);
    p_we = 1'b0; p_wd = 8'h00; p_bs = 1'b0; p_bsr = 2'd0;
    #1;
    check("small_read_A",   101, 64'(p_da),   64'hA5);
    check("small_read_B",   101, 64'(p_db),   64'h0);
    check("small_busy_B1",  101, 64'(p_bb),   64'h1);
    check("small_vec1",     101, 64'(p_bvec), 64'h4);
    @(negedge clk);
    p_we = 1'b1; p_wr = 2'd0; p_wd = 8'hFF; p_ra = 2'd0; p_rb = 2'd3;
    #1;
    check("small_r0_A",     102, 64'(p_da),   64'h0);
    @(negedge clk);
    p_we = 1'b0;
    #1;
    check("small_r0_after", 103, 64'(p_da),   64'h0);
    check("small_r3_B",     103, 64'(p_db),   64'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
